// File: rtl/pal_ctrl_pkg.sv
// Shared types and helpers for the palindrome sequencer.
package pal_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int DEF_NREQ        = 2;
   localparam int DEF_WIDTH       = 4;
   localparam int DEF_MAX_LEN     = 8;
   localparam int DEF_LEN_W       = 4;
   localparam int DEF_TIMEOUT_CYC = 64;

   // Never returns 0, so single-bit index fields stay legal.
   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pal_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module pal_rr_arbiter
   import pal_ctrl_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDW  = clog2_safe(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   always_comb begin
      int k;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      k   = 0;
      for (int i = 0; i < NREQ; i++) begin
         k = (int'(ptr) + i) % NREQ;
         if (!any && req[k]) begin
            any    = 1'b1;
            gnt[k] = 1'b1;
            idx    = k[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/palindrome_seq_ctrl.sv
// Shares one palindrome array among NREQ requesters, one string in flight.
// Optional watchdog on the verdict wait: define PAL_TIMEOUT_EN.
module palindrome_seq_ctrl
   import pal_ctrl_pkg::*;
#(
   parameter int NREQ        = DEF_NREQ,
   parameter int WIDTH       = DEF_WIDTH,
   parameter int MAX_LEN     = DEF_MAX_LEN,
   parameter int LEN_W       = DEF_LEN_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   localparam int IDW        = clog2_safe(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*LEN_W-1:0]  req_len,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ-1:0]        in_valid,
   input  logic [NREQ*WIDTH-1:0]  in_data,
   output logic [NREQ-1:0]        in_ready,
   output logic [NREQ-1:0]        rsp_valid,
   output logic                   rsp_pal,
   output logic                   rsp_err,
   input  logic [NREQ-1:0]        rsp_ready,
   output logic                   arr_valid,
   output logic [WIDTH-1:0]       arr_data,
   output logic                   arr_first,
   output logic                   arr_last,
   input  logic                   arr_ready,
   input  logic                   arr_res_valid,
   input  logic                   arr_res_pal,
   output logic                   arr_res_ready,
   output logic                   busy,
   output logic [IDW-1:0]         grant_id
);

   state_t           state, state_nx;
   logic [IDW-1:0]   rr_ptr, gid, arb_idx;
   logic [NREQ-1:0]  arb_gnt, gid_oh;
   logic             arb_any;
   logic [LEN_W-1:0] len, count, len_sel, len_m1;
   logic             pal_q, err_q;
   logic             beat, res_hs, len_zero, len_over, hold_grant, timeout;

   pal_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   assign len_sel  = req_len[arb_idx*LEN_W +: LEN_W];
   assign len_zero = (len_sel == '0);
   assign len_over = (int'(len_sel) > MAX_LEN);
   assign len_m1   = len - 1'b1;
   assign gid_oh   = {{(NREQ-1){1'b0}}, 1'b1} << gid;
   assign beat     = arr_valid & arr_ready;
   assign res_hs   = arr_res_valid & arr_res_ready;

`ifdef PAL_TIMEOUT_EN
   localparam int TW = clog2_safe(TIMEOUT_CYC + 1);
   logic [TW-1:0] wcnt;
   logic          flush;

   assign hold_grant = flush;
   assign timeout    = (state == WAIT) && !arr_res_valid && (wcnt == TW'(TIMEOUT_CYC - 1));

   // A timed-out verdict may still arrive later; swallow exactly one beat of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt  <= '0;
         flush <= 1'b0;
      end else begin
         wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;
         if (timeout)
            flush <= 1'b1;
         else if (flush && arr_res_valid)
            flush <= 1'b0;
      end
   end
`else
   assign hold_grant = 1'b0;
   assign timeout    = 1'b0;
`endif

   always_comb begin
      state_nx      = state;
      req_ready     = '0;
      in_ready      = '0;
      arr_valid     = 1'b0;
      arr_data      = in_data[gid*WIDTH +: WIDTH];
      arr_first     = 1'b0;
      arr_last      = 1'b0;
      arr_res_ready = 1'b0;
      rsp_valid     = '0;
      case (state)
         IDLE: begin
            if (!hold_grant) begin
               req_ready = arb_gnt;
               if (arb_any)
                  state_nx = (len_zero || len_over) ? RESP : STREAM;
            end
         end
         STREAM: begin
            arr_valid = in_valid[gid];
            in_ready  = arr_ready ? gid_oh : '0;
            arr_first = (count == '0);
            arr_last  = (count == len_m1);
            if (beat && arr_last)
               state_nx = WAIT;
         end
         WAIT: begin
            arr_res_ready = 1'b1;
            if (arr_res_valid || timeout)
               state_nx = RESP;
         end
         RESP: begin
            rsp_valid = gid_oh;
            if (rsp_ready[gid])
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
`ifdef PAL_TIMEOUT_EN
      if (flush)
         arr_res_ready = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= '0;
         gid    <= '0;
         len    <= '0;
         count  <= '0;
         pal_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (state_nx != IDLE) begin
                  gid    <= arb_idx;
                  len    <= len_sel;
                  count  <= '0;
                  rr_ptr <= (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
                  // Degenerate lengths answer directly without touching the array.
                  if (len_zero) begin
                     pal_q <= 1'b1;
                     err_q <= 1'b0;
                  end else if (len_over) begin
                     pal_q <= 1'b0;
                     err_q <= 1'b1;
                  end
               end
            end
            STREAM: if (beat) count <= count + 1'b1;
            WAIT: begin
               if (res_hs) begin
                  pal_q <= arr_res_pal;
                  err_q <= 1'b0;
               end else if (timeout) begin
                  pal_q <= 1'b0;
                  err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_pal  = pal_q;
   assign rsp_err  = err_q;
   assign busy     = (state != IDLE);
   assign grant_id = gid;

endmodule

// File: tb/tb_palindrome_seq_ctrl.sv
// Directed bench for palindrome_seq_ctrl; define PAL_TIMEOUT_EN to add the watchdog test.
module tb_palindrome_seq_ctrl;

   localparam int NREQ = 2, WIDTH = 4, MAX_LEN = 8, LEN_W = 4, TIMEOUT_CYC = 64;

   logic                  clk, rst_n;
   logic [NREQ-1:0]       req_valid, req_ready, in_valid, in_ready, rsp_valid, rsp_ready;
   logic [NREQ*LEN_W-1:0] req_len;
   logic [NREQ*WIDTH-1:0] in_data;
   logic                  rsp_pal, rsp_err;
   logic                  arr_valid, arr_first, arr_last, arr_ready;
   logic [WIDTH-1:0]      arr_data;
   logic                  arr_res_valid, arr_res_pal, arr_res_ready, busy;
   logic [0:0]            grant_id;

   int errors = 0;
   int checks = 0;
   int beats_seen = 0;
   logic [WIDTH-1:0] sym [0:MAX_LEN-1];

   palindrome_seq_ctrl #(
      .NREQ(NREQ), .WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .rsp_valid(rsp_valid), .rsp_pal(rsp_pal), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
      .arr_valid(arr_valid), .arr_data(arr_data), .arr_first(arr_first), .arr_last(arr_last),
      .arr_ready(arr_ready), .arr_res_valid(arr_res_valid), .arr_res_pal(arr_res_pal),
      .arr_res_ready(arr_res_ready), .busy(busy), .grant_id(grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (arr_valid && arr_ready) beats_seen++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_grant(input int r, input int len);
      req_len[r*LEN_W +: LEN_W] = LEN_W'(len);
      req_valid[r] = 1'b1;
      #1;
      chk("req_ready", 32'(req_ready), 32'(1 << r));
      tick();
      req_valid[r] = 1'b0;
      #1;
      chk("busy_after_grant", 32'(busy), 32'd1);
      chk("grant_id", 32'(grant_id), 32'(r));
   endtask

   task automatic do_stream(input int r, input int len, input int stall_beat);
      int b0;
      b0 = beats_seen;
      for (int i = 0; i < len; i++) begin
         in_valid[r] = 1'b1;
         in_data[r*WIDTH +: WIDTH] = sym[i];
         if (i == stall_beat) begin
            arr_ready = 1'b0;
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_first", 32'(arr_first), 32'(i == 0));
            chk("stall_last", 32'(arr_last), 32'(i == len - 1));
            tick();
         end
         arr_ready = 1'b1;
         #1;
         chk("arr_valid", 32'(arr_valid), 32'd1);
         chk("arr_data", 32'(arr_data), 32'(sym[i]));
         chk("arr_first", 32'(arr_first), 32'(i == 0));
         chk("arr_last", 32'(arr_last), 32'(i == len - 1));
         chk("in_ready", 32'(in_ready), 32'(1 << r));
         tick();
      end
      in_valid[r] = 1'b0;
      arr_ready   = 1'b0;
      chk("beat_count", 32'(beats_seen - b0), 32'(len));
   endtask

   task automatic do_verdict(input logic pal);
      chk("wait_res_ready", 32'(arr_res_ready), 32'd1);
      chk("wait_arr_valid", 32'(arr_valid), 32'd0);
      arr_res_valid = 1'b1;
      arr_res_pal   = pal;
      tick();
      arr_res_valid = 1'b0;
      arr_res_pal   = 1'b0;
   endtask

   task automatic do_resp(input int r, input logic pal, input logic err);
      #1;
      chk("rsp_valid", 32'(rsp_valid), 32'(1 << r));
      chk("rsp_pal", 32'(rsp_pal), 32'(pal));
      chk("rsp_err", 32'(rsp_err), 32'(err));
      rsp_ready[r] = 1'b1;
      tick();
      rsp_ready = '0;
      #1;
      chk("rsp_drop", 32'(rsp_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = '0; req_len = '0; in_valid = '0; in_data = '0; rsp_ready = '0;
      arr_ready = 1'b0; arr_res_valid = 1'b0; arr_res_pal = 1'b0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_pal_err", 32'({rsp_pal, rsp_err}), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_arr", 32'({arr_valid, arr_res_ready}), 32'd0);
      rst_n = 1'b1;
      tick();

      // Req0: 3,5,5,3 is a palindrome
      sym[0] = 4'd3; sym[1] = 4'd5; sym[2] = 4'd5; sym[3] = 4'd3;
      do_grant(0, 4);
      do_stream(0, 4, -1);
      do_verdict(1'b1);
      do_resp(0, 1'b1, 1'b0);

      // Fresh reset, both requesting with len 0: grants alternate 0,1,0,1
      rst_n = 1'b0;
      #1;
      chk("rst2_busy", 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      req_len = '0;
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_req_ready", 32'(req_ready), 32'(1 << (k % 2)));
         tick();
         chk("rr_grant_id", 32'(grant_id), 32'(k % 2));
         chk("rr_rsp_valid", 32'(rsp_valid), 32'(1 << (k % 2)));
         chk("rr_rsp_pal", 32'(rsp_pal), 32'd1);
         chk("rr_no_grant_in_resp", 32'(req_ready), 32'd0);
         rsp_ready = 2'b11;
         tick();
         rsp_ready = '0;
      end
      req_valid = '0;

      // Req1 len 0: immediate palindrome, no array beats
      do_grant(1, 0);
      chk("len0_arr_valid", 32'(arr_valid), 32'd0);
      do_resp(1, 1'b1, 1'b0);

      // Req0 len 9: length error, symbols never accepted
      do_grant(0, 9);
      in_valid[0] = 1'b1;
      #1;
      chk("over_in_ready", 32'(in_ready), 32'd0);
      chk("over_arr_valid", 32'(arr_valid), 32'd0);
      in_valid[0] = 1'b0;
      do_resp(0, 1'b0, 1'b1);

      // Req0 len 6 with a stall on beat 2; array says not a palindrome
      sym[0] = 4'd1; sym[1] = 4'd2; sym[2] = 4'd3; sym[3] = 4'd3; sym[4] = 4'd2; sym[5] = 4'd1;
      do_grant(0, 6);
      do_stream(0, 6, 2);
      do_verdict(1'b0);
      do_resp(0, 1'b0, 1'b0);

      // Req1 len MAX_LEN boundary
      for (int i = 0; i < MAX_LEN; i++) sym[i] = WIDTH'(i + 8);
      do_grant(1, 8);
      do_stream(1, 8, -1);
      do_verdict(1'b1);
      do_resp(1, 1'b1, 1'b0);

      // Verdict offered while idle is not taken
      arr_res_valid = 1'b1;
      #1;
      chk("idle_res_ready", 32'(arr_res_ready), 32'd0);
      arr_res_valid = 1'b0;

`ifdef PAL_TIMEOUT_EN
      sym[0] = 4'd7;
      do_grant(0, 1);
      do_stream(0, 1, -1);
      repeat (TIMEOUT_CYC - 1) tick();
      chk("to_still_wait", 32'(busy), 32'd1);
      chk("to_no_rsp_yet", 32'(rsp_valid), 32'd0);
      tick();
      do_resp(0, 1'b0, 1'b1);
      req_len[1*LEN_W +: LEN_W] = '0;
      req_valid[1] = 1'b1;
      #1;
      chk("flush_blocks_grant", 32'(req_ready), 32'd0);
      chk("flush_res_ready", 32'(arr_res_ready), 32'd1);
      repeat (8) tick();
      chk("flush_still_idle", 32'(busy), 32'd0);
      arr_res_valid = 1'b1;
      arr_res_pal   = 1'b1;
      tick();
      arr_res_valid = 1'b0;
      arr_res_pal   = 1'b0;
      chk("flush_cleared", 32'(arr_res_ready), 32'd0);
      chk("late_verdict_dropped", 32'(rsp_valid), 32'd0);
      chk("post_flush_req_ready", 32'(req_ready), 32'b10);
      tick();
      req_valid[1] = 1'b0;
      do_resp(1, 1'b1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
